initial_logic_nvc: RTL
======================

# initial_logic_nvc

Parametrised ingress stage for the PCIe transmission layer. A main FIFO receives words and a dispatcher routes each word to one of NUM_VC virtual-channel FIFOs, selected by the word's top class bits. Back-pressure is per channel: a stalled channel blocks only when the head word targets it. Thresholds are loaded during an init phase, and a small control FSM reports the block state.

## Interface
Parameters:
- DATA_WIDTH, 6, word width including class bits
- NUM_VC, 2, number of virtual channels (2..8)
- VC_SEL_W, 1, class bits; must equal clog2(NUM_VC)
- MAIN_AW, 3, main FIFO address width (depth 2^MAIN_AW)
- VC_AW, 2, VC FIFO address width (depth 2^VC_AW)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- init  in  1  synchronous re-initialisation and threshold load
- wr_enable  in  1  push data_in into the main FIFO
- data_in  in  DATA_WIDTH  input word; VC index = data_in[DATA_WIDTH-1 -: VC_SEL_W]
- pop_vc  in  NUM_VC  per-channel read request
- umbral_main  in  MAIN_AW+1  main almost-full threshold
- umbral_vc  in  NUM_VC*(VC_AW+1)  per-channel almost-full threshold; channel i at slice i
- data_out_vc  out  NUM_VC*DATA_WIDTH  registered read data per channel
- valid_vc  out  NUM_VC  data_out_vc slice valid, one cycle after an accepted pop
- full_main, empty_main, almost_full_main, error_main  out  1 each
- full_vc, empty_vc, almost_full_vc, almost_empty_vc, error_vc  out  NUM_VC each
- state  out  2  FSM state
- idle  out  1  high in IDLE

## Operation
- FSM states: RESET=0, INIT=1, IDLE=2, ACTIVE=3.
- Reset: the block enters RESET.
- init=1 in any state: the FSM goes to INIT. INIT clears pointers, counts, errors and pending registers, and samples umbral_main and umbral_vc every cycle. The last sampled values are held.
- In RESET with init=0, the FSM goes to IDLE on the next cycle.
- INIT with init=0: the FSM goes to IDLE.
- IDLE: the FSM goes to ACTIVE when any FIFO is non-empty or a push is pending.
- ACTIVE: the FSM goes to IDLE when all FIFOs are empty and nothing is pending.
- Writes and pops in RESET or INIT are ignored and do not set an error.
- The main FIFO is first-word-fall-through; its head word is visible combinationally to the dispatcher.
- Dispatch condition for destination d: !empty_main, state is IDLE or ACTIVE, and count_vc[d] + pending[d] < umbral_vc[d].
- When the dispatch condition holds, the main FIFO pops. The word is registered in the demux, and push_vc[d] is asserted on the next cycle.
- Head-of-line blocking applies to the destination channel only.
- Flags: full is count == depth; empty is count == 0; almost_full is count >= threshold; almost_empty is count <= 1.
- Push to a full FIFO: the write is dropped and the error is set.
- Pop from an empty FIFO: the pop is ignored, the error is set, and valid_vc stays 0.
- Errors are sticky until reset or init.
- Simultaneous push and pop on a non-full or non-empty FIFO: the count is unchanged and both operations complete.
- Pointers wrap modulo the depth. Counts are VC_AW+1 or MAIN_AW+1 bits wide.

## Timing
- Reset values: all empty flags = 1, almost_empty_vc = all 1. These outputs are 0: full, almost_full, error, valid_vc, data_out_vc, state=RESET, idle.
- wr_enable at edge t: empty_main = 0 after t.
- Dispatch pop occurs in the cycle after t.
- VC write occurs at the following edge.
- empty_vc[d] = 0 three edges after the main push.
- pop_vc[d] at edge t: data_out_vc[d] and valid_vc[d] are valid after t for one cycle.
- pending[d] is 1 exactly between a main pop and the VC write, so occupancy never exceeds umbral_vc[d] ≤ depth.
- Reset asserted mid-transfer: the pending word is lost and all outputs return to their reset values immediately.

## Structure
- A shared package holds the state encoding constants and the clog2 function.
- One sub-module, fifo_param (parameters: width, address width, FWFT mode), is instantiated once for main and NUM_VC times for the channels.
- The dispatcher, demux register and FSM live in the top level.

## Test plan
- Reset, then init with umbral_vc=2 and NUM_VC=2, then init=0 -> state goes 1 then 2; all empty flags = 1.
- Push 0x05 (VC0) and 0x25 (VC1) -> empty_vc = 2'b00 after 4 edges; pop both -> data_out shows 0x05 and 0x25 with valid_vc = 2'b11.
- Push four VC0 words with no pops -> VC0 holds 2 and main holds 2. Then push 0x21 -> it stays behind the VC0 head (head-of-line blocking). Pop VC0 -> traffic resumes.
- Push 9 words into an 8-deep main FIFO with VC0 blocked -> error_main = 1 and the 9th word is dropped. Init -> error clears.
- pop_vc[1] while VC1 is empty -> error_vc[1] = 1 and valid_vc[1] = 0.
- Assert reset while pending[0] = 1 -> all outputs return to reset values immediately and no push reaches VC0.

Source files
------------

// File: rtl/initial_logic_nvc_pkg.sv
// Shared definitions for the NVC ingress stage: control FSM encoding and a
// constant-evaluable clog2 used for parameter checking.
package initial_logic_nvc_pkg;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_e;

  function automatic int clog2_f(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/initial_logic_nvc_fifo_param.sv
// Parametrised FIFO with occupancy flags and sticky error. FWFT=1 exposes the
// head word combinationally; FWFT=0 returns read data one cycle after a pop.
module fifo_param #(
  parameter int WIDTH = 6,
  parameter int AW    = 2,
  parameter bit FWFT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  input  logic [AW:0]      thresh,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full,
  output logic             almost_full,
  output logic             error,
  output logic [AW:0]      count
);

  localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};

  logic [WIDTH-1:0] mem_q [2**AW];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             error_q;
  logic             empty;
  logic             wr_ok;
  logic             rd_ok;

  assign empty       = (count_q == '0);
  assign full        = (count_q == DEPTH_C);
  assign almost_full = (count_q >= thresh);
  assign error       = error_q;
  assign count       = count_q;
  assign wr_ok       = push & ~full;
  assign rd_ok       = pop & ~empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd_ok};
      // Rejected operations latch the error until reset or re-init.
      if ((push && full) || (pop && empty)) error_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !clear) mem_q[wr_ptr_q] <= din;
  end

  generate
    if (FWFT) begin : g_fwft
      assign dout  = mem_q[rd_ptr_q];
      assign valid = ~empty;
    end else begin : g_reg
      logic [WIDTH-1:0] rdata_q;
      logic             valid_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rdata_q <= '0;
          valid_q <= 1'b0;
        end else if (clear) begin
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_ok;
          if (rd_ok) rdata_q <= mem_q[rd_ptr_q];
        end
      end

      assign dout  = rdata_q;
      assign valid = valid_q;
    end
  endgenerate

endmodule

// File: rtl/initial_logic_nvc.sv
// Ingress stage: main FWFT FIFO dispatched by class bits into per-VC FIFOs
// through a one-word demux register, with a small control FSM.
module initial_logic_nvc
  import initial_logic_nvc_pkg::*;
#(
  parameter int DATA_WIDTH = 6,
  parameter int NUM_VC     = 2,
  parameter int VC_SEL_W   = 1,
  parameter int MAIN_AW    = 3,
  parameter int VC_AW      = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             init,
  input  logic                             wr_enable,
  input  logic [DATA_WIDTH-1:0]            data_in,
  input  logic [NUM_VC-1:0]                pop_vc,
  input  logic [MAIN_AW:0]                 umbral_main,
  input  logic [NUM_VC*(VC_AW+1)-1:0]      umbral_vc,
  output logic [NUM_VC*DATA_WIDTH-1:0]     data_out_vc,
  output logic [NUM_VC-1:0]                valid_vc,
  output logic                             full_main,
  output logic                             empty_main,
  output logic                             almost_full_main,
  output logic                             error_main,
  output logic [NUM_VC-1:0]                full_vc,
  output logic [NUM_VC-1:0]                empty_vc,
  output logic [NUM_VC-1:0]                almost_full_vc,
  output logic [NUM_VC-1:0]                almost_empty_vc,
  output logic [NUM_VC-1:0]                error_vc,
  output logic [1:0]                       state,
  output logic                             idle
);

  localparam int VCW   = VC_AW + 1;
  localparam int SEL_N = 2**VC_SEL_W;

  generate
    if (VC_SEL_W != clog2_f(NUM_VC)) begin : g_sel_check
      $error("VC_SEL_W must equal clog2(NUM_VC)");
    end
  endgenerate

  state_e                  state_q, state_d;
  logic                    op_en, clear, any_busy, dispatch, head_valid;
  logic [MAIN_AW:0]        thr_main_q, main_count;
  logic [NUM_VC*VCW-1:0]   thr_vc_q, count_vc;
  logic [DATA_WIDTH-1:0]   head_word, demux_q;
  logic [VC_SEL_W-1:0]     dst;
  logic [SEL_N-1:0]        room;
  logic [NUM_VC-1:0]       pend_q, pend_d;

  assign op_en      = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
  assign clear      = (state_q == ST_INIT);
  assign dst        = head_word[DATA_WIDTH-1 -: VC_SEL_W];
  assign dispatch   = head_valid & op_en & room[dst];
  assign empty_main = (main_count == '0);
  assign any_busy   = ~empty_main | ~(&empty_vc) | (|pend_q);
  assign state      = state_q;
  assign idle       = (state_q == ST_IDLE);

  fifo_param #(.WIDTH(DATA_WIDTH), .AW(MAIN_AW), .FWFT(1'b1)) u_main (
    .clk(clk), .reset(reset), .clear(clear),
    .push(wr_enable & op_en), .pop(dispatch), .din(data_in),
    .thresh(thr_main_q), .dout(head_word), .valid(head_valid),
    .full(full_main), .almost_full(almost_full_main),
    .error(error_main), .count(main_count)
  );

  genvar gi;
  generate
    // Reserved pending slot counts against the threshold so a channel never overfills.
    for (gi = 0; gi < SEL_N; gi++) begin : g_room
      if (gi < NUM_VC) begin : g_act
        assign room[gi] = (count_vc[gi*VCW +: VCW] + {{VC_AW{1'b0}}, pend_q[gi]})
                          < thr_vc_q[gi*VCW +: VCW];
      end else begin : g_none
        assign room[gi] = 1'b0;
      end
    end

    for (gi = 0; gi < NUM_VC; gi++) begin : g_vc
      assign pend_d[gi]          = dispatch && (dst == VC_SEL_W'(gi));
      assign empty_vc[gi]        = (count_vc[gi*VCW +: VCW] == '0);
      assign almost_empty_vc[gi] = (count_vc[gi*VCW +: VCW] <= VCW'(1));

      fifo_param #(.WIDTH(DATA_WIDTH), .AW(VC_AW), .FWFT(1'b0)) u_vc (
        .clk(clk), .reset(reset), .clear(clear),
        .push(pend_q[gi]), .pop(pop_vc[gi] & op_en), .din(demux_q),
        .thresh(thr_vc_q[gi*VCW +: VCW]),
        .dout(data_out_vc[gi*DATA_WIDTH +: DATA_WIDTH]), .valid(valid_vc[gi]),
        .full(full_vc[gi]), .almost_full(almost_full_vc[gi]),
        .error(error_vc[gi]), .count(count_vc[gi*VCW +: VCW])
      );
    end
  endgenerate

  // Thresholds default to full depth so almost_full stays low until init loads them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RESET;
      thr_main_q <= {1'b1, {MAIN_AW{1'b0}}};
      thr_vc_q   <= {NUM_VC{{1'b1, {VC_AW{1'b0}}}}};
      pend_q     <= '0;
      demux_q    <= '0;
    end else begin
      state_q <= state_d;
      if (clear) begin
        thr_main_q <= umbral_main;
        thr_vc_q   <= umbral_vc;
      end
      pend_q <= clear ? '0 : pend_d;
      if (dispatch) demux_q <= head_word;
    end
  end

  always_comb begin
    state_d = state_q;
    if (init) begin
      state_d = ST_INIT;
    end else begin
      case (state_q)
        ST_RESET, ST_INIT: state_d = ST_IDLE;
        ST_IDLE:           if (any_busy) state_d = ST_ACTIVE;
        ST_ACTIVE:         if (!any_busy) state_d = ST_IDLE;
        default:           state_d = ST_RESET;
      endcase
    end
  end

endmodule
